// File: rtl/switch_debouncer.sv
// Per-channel two-flop synchroniser plus stability-counter debounce filter.
// Emits a clean level and one-cycle rise/fall pulses for each switch.
module switch_debouncer #(
  parameter int N             = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] sw_raw,
  output logic [N-1:0] sw_clean,
  output logic [N-1:0] sw_rise,
  output logic [N-1:0] sw_fall,
  output logic         busy
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [N-1:0]     sync1_q, sync2_q;
  logic [N-1:0]     clean_q, clean_d;
  logic [N-1:0]     rise_q, rise_d;
  logic [N-1:0]     fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Any cycle where sync2 matches the clean level restarts the run.
  always_comb begin
    clean_d = clean_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != clean_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          clean_d[i] = sync2_q[i];
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign sw_clean = clean_q;
  assign sw_rise  = rise_q;
  assign sw_fall  = fall_q;
  assign busy     = |(sync2_q ^ clean_q);

endmodule

// File: tb/tb_switch_debouncer.sv
// Random and directed stimulus for switch_debouncer, checked against
// a history-window reference model of the debounce rules.
module tb_switch_debouncer;

  localparam int N = 2;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] sw_raw;
  logic [N-1:0] sw_clean, sw_rise, sw_fall;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [N-1:0] hist[$];
  int           last_acc[N];
  logic [N-1:0] m_clean, m_rise, m_fall;

  switch_debouncer #(.N(N), .STABLE_CYCLES(S)) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_raw   (sw_raw),
    .sw_clean (sw_clean),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h",
               tag, cyc, obs, exp);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    m_clean = '0;
    m_rise  = '0;
    m_fall  = '0;
    for (int i = 0; i < N; i++) last_acc[i] = -1;
  endfunction

  // Synchronised level seen by the filter at edge j (j counted since reset).
  function automatic logic [N-1:0] sync_at(input int j);
    return (j >= 2) ? hist[j-2] : '0;
  endfunction

  // A channel flips at edge k when the last S synchronised samples,
  // all taken after its previous flip, disagree with the clean level.
  function automatic void model_edge(input logic [N-1:0] raw);
    int  k;
    bit  ok;
    hist.push_back(raw);
    k = hist.size() - 1;
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < N; i++) begin
      ok = 1'b1;
      for (int j = k - S + 1; j <= k; j++) begin
        if (j < 0 || j <= last_acc[i]) ok = 1'b0;
        else if (sync_at(j)[i] == m_clean[i]) ok = 1'b0;
      end
      if (ok) begin
        m_clean[i]  = ~m_clean[i];
        m_rise[i]   = m_clean[i];
        m_fall[i]   = ~m_clean[i];
        last_acc[i] = k;
      end
    end
  endfunction

  function automatic logic model_busy();
    int k;
    k = hist.size() - 1;
    return |(sync_at(k + 1) ^ m_clean);
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge(sw_raw);
    #1;
    cyc++;
    chk("clean", 32'(sw_clean), 32'(m_clean));
    chk("rise",  32'(sw_rise),  32'(m_rise));
    chk("fall",  32'(sw_fall),  32'(m_fall));
    chk("busy",  32'(busy),     32'(model_busy()));
  endtask

  task automatic hold(input logic [N-1:0] v, input int n);
    for (int c = 0; c < n; c++) begin
      sw_raw = v;
      step();
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_clean"}, 32'(sw_clean), 32'd0);
    chk({tag, "_rise"},  32'(sw_rise),  32'd0);
    chk({tag, "_fall"},  32'(sw_fall),  32'd0);
    chk({tag, "_busy"},  32'(busy),     32'd0);
  endtask

  // Reset asserted between edges, held a few edges, released between edges.
  task automatic do_reset(input int n);
    #2;
    reset = 1'b1;
    #1;
    chk_zero("rst_async");
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      chk_zero("rst_hold");
    end
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset  = 1'b1;
    sw_raw = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("por");
    #2;
    reset = 1'b0;

    hold(2'b00, 20);
    hold(2'b01, 10);
    hold(2'b11, 3);
    hold(2'b01, 10);
    hold(2'b00, 10);
    hold(2'b01, 1); hold(2'b00, 1); hold(2'b01, 2);
    hold(2'b00, 1); hold(2'b01, 10);
    hold(2'b00, 10);
    hold(2'b11, 10);
    hold(2'b00, 10);

    hold(2'b11, 4);
    sw_raw = 2'b11;
    do_reset(3);
    hold(2'b11, 10);
    hold(2'b00, 10);

    for (int seg = 0; seg < 400; seg++) begin
      if ($urandom_range(0, 39) == 0) begin
        sw_raw = N'($urandom);
        do_reset($urandom_range(1, 3));
      end
      hold(N'($urandom), $urandom_range(1, 2 * S + 2));
    end
    hold(2'b00, 12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Conditions raw mechanical switch levels before they drive relay coil inputs (the switch1/switch2 style inputs of relay networks).
- Per channel: synchronises the raw level to clk, then filters bounce with a stability counter.
- Outputs a clean level plus one-cycle rise and fall pulses.
- Sits directly upstream of the relay stages, so relay/gate models see only settled, glitch-free switch levels.

Parameters:
- N, 2, number of independent switch channels (N >= 1).
- STABLE_CYCLES, 4, consecutive synchronised cycles a new level must hold before it is accepted (>= 2).
- CNT_W, $clog2(STABLE_CYCLES), counter width per channel; derived, not overridden.

Ports:
- clk  input  1  single system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- sw_raw  input  N  raw switch levels; asynchronous to clk and may bounce.
- sw_clean  output  N  debounced level per channel; registered.
- sw_rise  output  N  one-cycle pulse when sw_clean goes 0->1; registered.
- sw_fall  output  N  one-cycle pulse when sw_clean goes 1->0; registered.
- busy  output  1  high while any channel's synchronised level differs from its sw_clean.

Behaviour:
- Reset (asserted asynchronously, any time):
  - Clears both synchroniser stages, all counters, sw_clean, sw_rise and sw_fall to 0.
  - busy reads 0 during reset.
  - A count in progress is discarded. No pulse is emitted on reset entry or exit.
- Synchroniser: per channel, two flops, sync1 <= sw_raw[i], sync2 <= sync1. Only sync2 is used downstream.
- Per-channel filter, evaluated at each rising clk edge:
  - sync2 == sw_clean: cnt <= 0; sw_clean holds; rise/fall <= 0.
  - sync2 != sw_clean and cnt < STABLE_CYCLES-1: cnt <= cnt+1; rise/fall <= 0.
  - sync2 != sw_clean and cnt == STABLE_CYCLES-1: sw_clean <= sync2; cnt <= 0; sw_rise or sw_fall <= 1 according to the new level.
- Pulse timing: sw_rise/sw_fall are high for exactly one cycle, in the same cycle sw_clean first shows the new level. They are never both high on one channel.
- Latency: a clean raw step sampled at edge E appears on sw_clean after edge E+STABLE_CYCLES+1, i.e. STABLE_CYCLES+2 edges including E. Default: 6 cycles.
- Glitch rejection: if sync2 returns to sw_clean before the count completes, cnt resets to 0. Any bounce pattern restarts the count; only an unbroken run is accepted.
- Minimum spacing: accepted transitions on one channel are at least STABLE_CYCLES cycles apart.
- Counter saturation: cnt never exceeds STABLE_CYCLES-1, and it cannot wrap.
- Channel independence: channels share only clk, reset and busy. Simultaneous transitions on several channels are each reported in the same cycle.
- busy: combinational OR over channels of (sync2 != sw_clean). It is 0 whenever all channels are settled.
- Raw input held constant: outputs stay constant indefinitely, with no periodic pulses.

Test Plan:
- Reset, sw_raw=2'b00 held for 20 cycles -> sw_clean=00, no rise/fall pulses, busy=0 throughout.
- sw_raw[0] 0->1 at edge 0 and held -> busy=1 from edge 2. sw_clean=01 and sw_rise=01 (single cycle) after edge 5. busy=0 after edge 5.
- sw_raw[1] high for 3 cycles then low -> sw_clean[1] stays 0, no sw_rise[1]. busy pulses high then returns to 0.
- Bounce on sw_raw[0] (1,0,1,1,0,1 then steady 1) -> exactly one sw_rise[0]. It arrives 6 cycles after the final steady 1 is sampled.
- Both channels 0->1 on the same edge, later both 1->0 -> sw_rise=11 in one cycle, then sw_fall=11 in one cycle. sw_clean=11, then 00.
- Assert reset mid-count (cnt=2, sw_raw=11), release with sw_raw still 11 -> outputs 0 during reset. After release, a full 6-cycle latency elapses before sw_clean=11, with no early pulse.
